cache_axi_burst: RTL and testbench

//  Parametrised cache-line transfer engine between a cache controller and the burst-level AXI master.

---
 rtl/cache_axi_burst.sv | 123 ++++++++++++
 tb/tb_cache_axi_burst.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_burst.sv
// Moves one cache line between the cache controller and the AXI burst unit as NBURST bursts, with one ack per line.
// Build option: define CACHE_AXI_CWF_EN to send the burst holding the requested address first.
module cache_axi_burst #(
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BEATS  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cache_rw_req,
  input  logic [ADDR_W-1:0]             i_cache_rw_addr,
  input  logic                          i_cache_rw_op,
  input  logic [8*LINE_BYTES-1:0]       i_cache_rw_wdata,
  output logic [8*LINE_BYTES-1:0]       o_cache_rw_rdata,
  output logic                          o_cache_rw_ack,
  output logic                          o_cache_rw_busy,
  output logic                          o_axi_op,
  output logic                          o_axi_valid,
  input  logic                          i_axi_ready,
  output logic [ADDR_W-1:0]             o_axi_addr,
  output logic [64*BEAT_BYTES*MAX_BEATS/8-1:0] o_axi_wdata,
  input  logic [64*BEAT_BYTES*MAX_BEATS/8-1:0] i_axi_rdata,
  output logic [1:0]                    o_axi_size,
  output logic [7:0]                    o_axi_blks
);
  localparam int LINE_BITS   = 8 * LINE_BYTES;
  localparam int BURST_BYTES = BEAT_BYTES * MAX_BEATS;
  localparam int BURST_BITS  = 8 * BURST_BYTES;
  localparam int NBURST      = LINE_BYTES / BURST_BYTES;
  localparam int IDX_W       = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int BURST_SH    = $clog2(BURST_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBURST - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t               state;
  logic                 armed;
  logic                 op;
  logic [ADDR_W-1:0]    base;
  logic [LINE_BITS-1:0] wline;
  logic [LINE_BITS-1:0] rline;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     cnt;
  logic [IDX_W-1:0]     start_idx;
  logic                 valid;
  logic                 ack;
  logic                 busy;

`ifdef CACHE_AXI_CWF_EN
  // Low bits of the burst number inside the line; NBURST is a power of two.
  assign start_idx = (NBURST > 1) ? IDX_W'(i_cache_rw_addr >> BURST_SH) : '0;
`else
  assign start_idx = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b1;
      op    <= 1'b0;
      base  <= '0;
      wline <= '0;
      rline <= '0;
      idx   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      ack   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!i_cache_rw_req) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (i_cache_rw_req && armed) begin
            op    <= i_cache_rw_op;
            base  <= i_cache_rw_addr & ~ADDR_W'(LINE_BYTES - 1);
            wline <= i_cache_rw_wdata;
            idx   <= start_idx;
            cnt   <= '0;
            armed <= 1'b0;
            valid <= 1'b1;
            busy  <= 1'b1;
            state <= XFER;
          end
        end
        XFER: begin
          if (i_axi_ready) begin
            if (!op) rline[idx*BURST_BITS +: BURST_BITS] <= i_axi_rdata;
            if (cnt == LAST_IDX) begin
              valid <= 1'b0;
              ack   <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
              idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_axi_addr       = base + (ADDR_W'(idx) << BURST_SH);
  assign o_axi_wdata      = wline[idx*BURST_BITS +: BURST_BITS];
  assign o_axi_op         = op;
  assign o_axi_valid      = valid;
  assign o_cache_rw_ack   = ack;
  assign o_cache_rw_busy  = busy;
  assign o_cache_rw_rdata = rline;
  assign o_axi_size       = 2'($clog2(BEAT_BYTES));
  assign o_axi_blks       = 8'(MAX_BEATS - 1);

endmodule

// File: tb/tb_cache_axi_burst.sv
// Scoreboard bench for cache_axi_burst: three instances with 1, 2 and 4 bursts per line (64-byte bursts).
// Expected burst order follows CACHE_AXI_CWF_EN when the bench is built with it.
module tb_cache_axi_burst;
  typedef struct {
    logic        op;
    logic [63:0] addr;
    logic [511:0] wdata;
  } burst_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  burst_t qb_a[$], qb_b[$], qb_c[$];
  logic [2047:0] qa_a[$], qa_b[$], qa_c[$];
  logic [2047:0] exp_rd [3];

  // a: 128-byte line, b: 256-byte line, c: 64-byte line
  logic          req_a, req_b, req_c, op_a, op_b, op_c;
  logic [63:0]   addr_a, addr_b, addr_c;
  logic [1023:0] wdata_a, rdata_a;
  logic [2047:0] wdata_b, rdata_b;
  logic [511:0]  wdata_c, rdata_c;
  logic          ack_a, ack_b, ack_c, busy_a, busy_b, busy_c;
  logic          aop_a, aop_b, aop_c, valid_a, valid_b, valid_c;
  logic          ready_a, ready_b, ready_c;
  logic [63:0]   aaddr_a, aaddr_b, aaddr_c;
  logic [511:0]  awd_a, awd_b, awd_c, ard_a, ard_b, ard_c;
  logic [1:0]    size_a, size_b, size_c;
  logic [7:0]    blks_a, blks_b, blks_c;

  cache_axi_burst #(.LINE_BYTES(128)) dut_a (
    .clk(clk), .rst(rst), .i_cache_rw_req(req_a), .i_cache_rw_addr(addr_a), .i_cache_rw_op(op_a),
    .i_cache_rw_wdata(wdata_a), .o_cache_rw_rdata(rdata_a), .o_cache_rw_ack(ack_a), .o_cache_rw_busy(busy_a),
    .o_axi_op(aop_a), .o_axi_valid(valid_a), .i_axi_ready(ready_a), .o_axi_addr(aaddr_a),
    .o_axi_wdata(awd_a), .i_axi_rdata(ard_a), .o_axi_size(size_a), .o_axi_blks(blks_a));

  cache_axi_burst #(.LINE_BYTES(256)) dut_b (
    .clk(clk), .rst(rst), .i_cache_rw_req(req_b), .i_cache_rw_addr(addr_b), .i_cache_rw_op(op_b),
    .i_cache_rw_wdata(wdata_b), .o_cache_rw_rdata(rdata_b), .o_cache_rw_ack(ack_b), .o_cache_rw_busy(busy_b),
    .o_axi_op(aop_b), .o_axi_valid(valid_b), .i_axi_ready(ready_b), .o_axi_addr(aaddr_b),
    .o_axi_wdata(awd_b), .i_axi_rdata(ard_b), .o_axi_size(size_b), .o_axi_blks(blks_b));

  cache_axi_burst #(.LINE_BYTES(64)) dut_c (
    .clk(clk), .rst(rst), .i_cache_rw_req(req_c), .i_cache_rw_addr(addr_c), .i_cache_rw_op(op_c),
    .i_cache_rw_wdata(wdata_c), .o_cache_rw_rdata(rdata_c), .o_cache_rw_ack(ack_c), .o_cache_rw_busy(busy_c),
    .o_axi_op(aop_c), .o_axi_valid(valid_c), .i_axi_ready(ready_c), .o_axi_addr(aaddr_c),
    .o_axi_wdata(awd_c), .i_axi_rdata(ard_c), .o_axi_size(size_c), .o_axi_blks(blks_c));

  function automatic logic [511:0] pat(input logic [63:0] a);
    logic [511:0] r;
    for (int w = 0; w < 8; w++) r[w*64 +: 64] = a ^ (64'h1111_0000_0000_0000 * 64'(w + 1));
    return r;
  endfunction

  function automatic logic [2047:0] mkline(input logic [63:0] seed);
    logic [2047:0] r;
    for (int w = 0; w < 32; w++) r[w*64 +: 64] = seed | 64'(w);
    return r;
  endfunction

  // Slave returns address-derived data so misplaced slices are visible.
  always_comb ard_a = pat(aaddr_a);
  always_comb ard_b = pat(aaddr_b);
  always_comb ard_c = pat(aaddr_c);

  task automatic chk(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int w = 0; w < 32; w++) begin
        if (act[w*64 +: 64] !== exp[w*64 +: 64]) begin
          $display("FAIL %s: word %0d got %h expected %h", nm, w, act[w*64 +: 64], exp[w*64 +: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic ackof(input int s);
    case (s)
      0: return ack_a;
      1: return ack_b;
      default: return ack_c;
    endcase
  endfunction

  function automatic logic validof(input int s);
    case (s)
      0: return valid_a;
      1: return valid_b;
      default: return valid_c;
    endcase
  endfunction

  // Issue a line request and queue the bursts and final line the model expects.
  task automatic start(input int sel, input logic [63:0] a, input logic o, input logic [2047:0] wd);
    int nb, s, ix;
    logic [63:0] base;
    burst_t b;
    nb   = (sel == 0) ? 2 : (sel == 1) ? 4 : 1;
    base = a & ~(64'(nb * 64) - 64'd1);
`ifdef CACHE_AXI_CWF_EN
    s = int'((a - base) >> 6);
`else
    s = 0;
`endif
    for (int k = 0; k < nb; k++) begin
      ix = (s + k) % nb;
      b.op = o;
      b.addr = base + 64'(ix * 64);
      b.wdata = wd[ix*512 +: 512];
      if (!o) exp_rd[sel][ix*512 +: 512] = pat(b.addr);
      case (sel)
        0: qb_a.push_back(b);
        1: qb_b.push_back(b);
        default: qb_c.push_back(b);
      endcase
    end
    case (sel)
      0: begin qa_a.push_back(exp_rd[0]); addr_a = a; op_a = o; wdata_a = wd[1023:0]; req_a = 1'b1; end
      1: begin qa_b.push_back(exp_rd[1]); addr_b = a; op_b = o; wdata_b = wd; req_b = 1'b1; end
      default: begin qa_c.push_back(exp_rd[2]); addr_c = a; op_c = o; wdata_c = wd[511:0]; req_c = 1'b1; end
    endcase
  endtask

  task automatic drop(input int sel);
    @(posedge clk); #1;
    case (sel)
      0: req_a = 1'b0;
      1: req_b = 1'b0;
      default: req_c = 1'b0;
    endcase
  endtask

  // Negedges from the request cycle until ack; the request cycle itself counts as 0.
  task automatic wait_ack(input int sel, input int exp_lat, input string nm);
    int i = 0;
    @(negedge clk);
    while (!ackof(sel) && i < 200) begin @(negedge clk); i++; end
    chk(nm, 2048'(i), 2048'(exp_lat));
  endtask

  task automatic wait_valid(input int sel, input string nm);
    int i = 0;
    @(negedge clk);
    while (!validof(sel) && i < 200) begin @(negedge clk); i++; end
    chk(nm, 2048'(i), 2048'd1);
  endtask

  burst_t eb_a, eb_b, eb_c;

  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      chk("a_burst_expected", 2048'(qb_a.size() != 0), 2048'd1);
      if (qb_a.size() != 0) begin
        eb_a = qb_a.pop_front();
        chk("a_addr", 2048'(aaddr_a), 2048'(eb_a.addr));
        chk("a_op", 2048'(aop_a), 2048'(eb_a.op));
        if (eb_a.op) chk("a_wdata", 2048'(awd_a), 2048'(eb_a.wdata));
      end
    end
    if (ack_a) begin
      chk("a_ack_expected", 2048'(qa_a.size() != 0), 2048'd1);
      if (qa_a.size() != 0) chk("a_rdata", 2048'(rdata_a), qa_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (valid_b && ready_b) begin
      chk("b_burst_expected", 2048'(qb_b.size() != 0), 2048'd1);
      if (qb_b.size() != 0) begin
        eb_b = qb_b.pop_front();
        chk("b_addr", 2048'(aaddr_b), 2048'(eb_b.addr));
        chk("b_op", 2048'(aop_b), 2048'(eb_b.op));
        if (eb_b.op) chk("b_wdata", 2048'(awd_b), 2048'(eb_b.wdata));
      end
    end
    if (ack_b) begin
      chk("b_ack_expected", 2048'(qa_b.size() != 0), 2048'd1);
      if (qa_b.size() != 0) chk("b_rdata", rdata_b, qa_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (valid_c && ready_c) begin
      chk("c_burst_expected", 2048'(qb_c.size() != 0), 2048'd1);
      if (qb_c.size() != 0) begin
        eb_c = qb_c.pop_front();
        chk("c_addr", 2048'(aaddr_c), 2048'(eb_c.addr));
        chk("c_op", 2048'(aop_c), 2048'(eb_c.op));
        if (eb_c.op) chk("c_wdata", 2048'(awd_c), 2048'(eb_c.wdata));
      end
    end
    if (ack_c) begin
      chk("c_ack_expected", 2048'(qa_c.size() != 0), 2048'd1);
      if (qa_c.size() != 0) chk("c_rdata", 2048'(rdata_c), qa_c.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_a = 0; req_b = 0; req_c = 0; op_a = 0; op_b = 0; op_c = 0;
    addr_a = '0; addr_b = '0; addr_c = '0; wdata_a = '0; wdata_b = '0; wdata_c = '0;
    ready_a = 1; ready_b = 1; ready_c = 1;
    for (int s = 0; s < 3; s++) exp_rd[s] = '0;
    #3;
    chk("rst_valid", 2048'(valid_a), 2048'd0);
    chk("rst_ack", 2048'(ack_a), 2048'd0);
    chk("rst_busy", 2048'(busy_a), 2048'd0);
    chk("rst_rdata", 2048'(rdata_a), 2048'd0);
    chk("rst_addr", 2048'(aaddr_a), 2048'd0);
    chk("rst_op", 2048'(aop_a), 2048'd0);
    chk("axi_size", 2048'(size_a), 2048'd3);
    chk("axi_blks", 2048'(blks_a), 2048'd7);
    @(posedge clk); #1 rst = 1'b1;

    // Single-burst line read, ready tied high
    @(posedge clk); #1;
    start(2, 64'h8000_0010, 1'b0, '0);
    wait_ack(2, 2, "c_read_latency");
    drop(2);

    // Two-burst line write, then req held high after ack
    @(posedge clk); #1;
    start(0, 64'h1040, 1'b1, mkline(64'hA000_0000_0000_0000));
    wait_ack(0, 3, "a_write_latency");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("a_hold_no_valid", 2048'(valid_a), 2048'd0);
      chk("a_hold_not_busy", 2048'(busy_a), 2048'd0);
    end
    @(posedge clk); #1 req_a = 1'b0;
    @(posedge clk); #1;
    start(0, 64'h10C4, 1'b0, '0);
    wait_ack(0, 3, "a_rearm_latency");
    drop(0);

    // Ready held low on the first burst for 10 cycles
    @(posedge clk); #1;
    ready_a = 1'b0;
    start(0, 64'h1010, 1'b0, '0);
    wait_valid(0, "a_valid_rise");
    for (int k = 0; k < 10; k++) begin
      chk("a_stall_valid", 2048'(valid_a), 2048'd1);
      chk("a_stall_addr", 2048'(aaddr_a), 2048'h1000);
      @(negedge clk);
    end
    @(posedge clk); #1 ready_a = 1'b1;
    wait_ack(0, 2, "a_ack_after_ready");
    drop(0);

    // Reset during the second of two bursts
    @(posedge clk); #1;
    ready_a = 1'b0;
    start(0, 64'h2008, 1'b0, '0);
    wait_valid(0, "a_valid_rise_rst");
    @(posedge clk); #1 ready_a = 1'b1;
    @(posedge clk); #1 ready_a = 1'b0;
    @(negedge clk);
    chk("a_burst2_valid", 2048'(valid_a), 2048'd1);
    chk("a_burst2_addr", 2048'(aaddr_a), 2048'h2040);
    #2 rst = 1'b0;
    req_a = 1'b0;
    #1;
    chk("a_rst_valid_async", 2048'(valid_a), 2048'd0);
    chk("a_rst_busy_async", 2048'(busy_a), 2048'd0);
    chk("a_rst_rdata", 2048'(rdata_a), 2048'd0);
    qb_a.delete();
    qa_a.delete();
    for (int s = 0; s < 3; s++) exp_rd[s] = '0;
    ready_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("a_post_rst_idle", 2048'(busy_a), 2048'd0);
    @(posedge clk); #1;
    start(0, 64'h2008, 1'b0, '0);
    wait_ack(0, 3, "a_post_rst_latency");
    drop(0);

    // Four-burst line read and write
    @(posedge clk); #1;
    start(1, 64'h20C8, 1'b0, '0);
    wait_ack(1, 5, "b_read_latency");
    drop(1);
    @(posedge clk); #1;
    start(1, 64'h3048, 1'b1, mkline(64'hB000_0000_0000_0000));
    wait_ack(1, 5, "b_write_latency");
    drop(1);

    // Single-burst write leaves the cleared read line untouched
    @(posedge clk); #1;
    start(2, 64'h44, 1'b1, mkline(64'hC000_0000_0000_0000));
    wait_ack(2, 2, "c_write_latency");
    drop(2);

    repeat (3) @(negedge clk);
    chk("a_bursts_left", 2048'(qb_a.size()), 2048'd0);
    chk("b_bursts_left", 2048'(qb_b.size()), 2048'd0);
    chk("c_bursts_left", 2048'(qb_c.size()), 2048'd0);
    chk("a_acks_left", 2048'(qa_a.size()), 2048'd0);
    chk("b_acks_left", 2048'(qa_b.size()), 2048'd0);
    chk("c_acks_left", 2048'(qa_c.size()), 2048'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
